// File: rtl/guess_game_ctrl_if.sv
// Signal bundle between the guessing-game sequencer and the board/comparator side.
interface guess_game_ctrl_if;
  // Board switches/buttons and comparator result
  logic       start;
  logic       guessBtn;
  logic       useRandom;
  logic [3:0] secret_in;
  logic [3:0] sw_number;
  logic [2:0] cmp_state;
  // Sequencer outputs to comparator and status LEDs
  logic [3:0] number;
  logic [3:0] in_number;
  logic       isGuess;
  logic [2:0] hint;
  logic [3:0] tries;
  logic       win;
  logic       lose;
  logic       busy;

  // Board / comparator side
  modport master (
    output start, guessBtn, useRandom, secret_in, sw_number, cmp_state,
    input  number, in_number, isGuess, hint, tries, win, lose, busy
  );

  // Sequencer side
  modport slave (
    input  start, guessBtn, useRandom, secret_in, sw_number, cmp_state,
    output number, in_number, isGuess, hint, tries, win, lose, busy
  );
endinterface

// File: rtl/guess_game_ctrl.sv
// Guessing-game sequencer: holds the secret, registers guesses on a button
// edge, strobes the comparator for one cycle, and tracks tries/win/lose.
module guess_game_ctrl #(
  parameter int         MAX_TRIES = 7,
  parameter logic [3:0] LFSR_SEED = 4'b0001
) (
  input  logic              clk,
  input  logic              reset_n,
  guess_game_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_CHECK,
    S_WIN,
    S_LOSE
  } state_t;

  state_t     r_state;
  logic       r_start_q;
  logic       r_guess_q;
  logic [3:0] r_lfsr;
  logic [3:0] r_number;
  logic [3:0] r_in_number;
  logic       r_is_guess;
  logic [2:0] r_hint;
  logic [3:0] r_tries;
  logic       r_win;
  logic       r_lose;
  logic       r_busy;

  logic       w_start_edge;
  logic       w_guess_edge;
  logic [3:0] w_tries_inc;
  logic [3:0] w_max_tries;

  assign w_start_edge = bus.start & ~r_start_q;
  assign w_guess_edge = bus.guessBtn & ~r_guess_q;
  assign w_tries_inc  = r_tries + 4'd1;
  assign w_max_tries  = 4'(MAX_TRIES);

  // Button history for rising-edge detection, updated in every state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_q <= 1'b0;
      r_guess_q <= 1'b0;
    end else begin
      r_start_q <= bus.start;
      r_guess_q <= bus.guessBtn;
    end
  end

  // Free-running x^4+x^3+1 LFSR; the seed is nonzero so it never locks at 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
    end
  end

  // Game FSM; start edge outranks guess edge wherever both are honoured
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_number    <= 4'd0;
      r_in_number <= 4'd0;
      r_is_guess  <= 1'b0;
      r_hint      <= 3'b111;
      r_tries     <= 4'd0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Strobe is only re-armed on the WAIT->CHECK transition
      r_is_guess <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state <= S_ARM;
            r_busy  <= 1'b1;
          end
        end
        S_ARM: begin
          r_number <= bus.useRandom ? r_lfsr : bus.secret_in;
          r_tries  <= 4'd0;
          r_hint   <= 3'b111;
          r_win    <= 1'b0;
          r_lose   <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (w_start_edge) begin
            r_state <= S_ARM;
          end else if (w_guess_edge) begin
            r_in_number <= bus.sw_number;
            r_is_guess  <= 1'b1;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          // An abort here drops the comparator result entirely
          if (w_start_edge) begin
            r_state <= S_ARM;
          end else begin
            r_hint  <= bus.cmp_state;
            r_tries <= w_tries_inc;
            if (bus.cmp_state == 3'b000) begin
              r_win   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_WIN;
            end else if (w_tries_inc == w_max_tries) begin
              r_lose  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_LOSE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WIN, S_LOSE: begin
          if (w_start_edge) begin
            r_state <= S_ARM;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.number    = r_number;
  assign bus.in_number = r_in_number;
  assign bus.isGuess   = r_is_guess;
  assign bus.hint      = r_hint;
  assign bus.tries     = r_tries;
  assign bus.win       = r_win;
  assign bus.lose      = r_lose;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl: one DUT with the default try limit,
// one with a limit of 3, each paired with a behavioural comparator.
module tb_guess_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  int         checks = 0;
  int         errors = 0;
  int         cnt;
  logic [3:0] tab [15];
  logic [3:0] exp_num;

  guess_game_ctrl_if g7 ();
  guess_game_ctrl_if g3 ();

  guess_game_ctrl #(.MAX_TRIES(7), .LFSR_SEED(4'b0001)) dut7 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (g7)
  );

  guess_game_ctrl #(.MAX_TRIES(3), .LFSR_SEED(4'b0001)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (g3)
  );

  always #5 clk = ~clk;

  // Comparator: highest differing bit position, 000 when equal
  function automatic logic [2:0] cmp_model(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    d = a ^ b;
    if (d[3])      return 3'b100;
    else if (d[2]) return 3'b011;
    else if (d[1]) return 3'b010;
    else if (d[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  always_comb g7.cmp_state = cmp_model(g7.number, g7.in_number);
  always_comb g3.cmp_state = cmp_model(g3.number, g3.in_number);

  // Clock edges since reset release, to index the LFSR table
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= 0;
    else          cnt <= cnt + 1;
  end

  function automatic logic [18:0] pk7();
    return {g7.number, g7.in_number, g7.isGuess, g7.hint, g7.tries, g7.win, g7.lose, g7.busy};
  endfunction

  function automatic logic [18:0] pk3();
    return {g3.number, g3.in_number, g3.isGuess, g3.hint, g3.tries, g3.win, g3.lose, g3.busy};
  endfunction

  localparam logic [18:0] RST_VAL = {4'd0, 4'd0, 1'b0, 3'b111, 4'd0, 1'b0, 1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Expected LFSR state after k clocks out of reset (seed 0001)
    tab[0]  = 4'h1; tab[1]  = 4'h2; tab[2]  = 4'h4; tab[3]  = 4'h9; tab[4]  = 4'h3;
    tab[5]  = 4'h6; tab[6]  = 4'hD; tab[7]  = 4'hA; tab[8]  = 4'h5; tab[9]  = 4'hB;
    tab[10] = 4'h7; tab[11] = 4'hF; tab[12] = 4'hE; tab[13] = 4'hC; tab[14] = 4'h8;

    reset_n = 1'b0;
    g7.start = 0; g7.guessBtn = 0; g7.useRandom = 0; g7.secret_in = 4'b1010; g7.sw_number = 0;
    g3.start = 0; g3.guessBtn = 0; g3.useRandom = 0; g3.secret_in = 4'b1010; g3.sw_number = 0;
    step(2);
    chk("reset_outputs", 32'(pk7()), 32'(RST_VAL));
    reset_n = 1'b1;
    step(1);

    // Manual secret, game start
    g7.start = 1;
    step(1);
    chk("arm_busy", 32'(g7.busy), 1);
    chk("arm_number_not_yet", 32'(g7.number), 0);
    g7.start = 0;
    step(1);
    chk("wait_state", 32'(pk7()), 32'({4'b1010, 4'd0, 1'b0, 3'b111, 4'd0, 1'b0, 1'b0, 1'b1}));

    // Wrong guess
    g7.sw_number = 4'b0010; g7.guessBtn = 1;
    step(1);
    chk("check1_isguess", 32'(g7.isGuess), 1);
    chk("check1_in_number", 32'(g7.in_number), 4'b0010);
    g7.guessBtn = 0;
    step(1);
    chk("after1", 32'(pk7()), 32'({4'b1010, 4'b0010, 1'b0, 3'b100, 4'd1, 1'b0, 1'b0, 1'b1}));

    // Correct guess
    g7.sw_number = 4'b1010; g7.guessBtn = 1;
    step(1);
    chk("check2_isguess", 32'(g7.isGuess), 1);
    g7.guessBtn = 0;
    step(1);
    chk("win", 32'(pk7()), 32'({4'b1010, 4'b1010, 1'b0, 3'b000, 4'd2, 1'b1, 1'b0, 1'b0}));
    g7.guessBtn = 1;
    step(1);
    chk("win_ignore_isguess", 32'(g7.isGuess), 0);
    g7.guessBtn = 0;
    step(2);
    chk("win_ignore_tries", 32'({g7.tries, g7.win}), 32'({4'd2, 1'b1}));

    // Restart, then hold the guess button for several cycles
    g7.start = 1;
    step(1);
    g7.start = 0;
    step(1);
    chk("restart", 32'({g7.tries, g7.win, g7.hint}), 32'({4'd0, 1'b0, 3'b111}));
    g7.sw_number = 4'b0010; g7.guessBtn = 1;
    step(5);
    chk("held_button", 32'({g7.tries, g7.hint, g7.isGuess}), 32'({4'd1, 3'b100, 1'b0}));
    g7.guessBtn = 0;
    step(1);

    // Same-cycle start and guess in WAIT
    g7.start = 1; g7.guessBtn = 1;
    step(1);
    chk("prio_arm", 32'({g7.isGuess, g7.busy}), 32'({1'b0, 1'b1}));
    g7.start = 0; g7.guessBtn = 0;
    step(1);
    chk("prio_wait", 32'({g7.tries, g7.hint, g7.isGuess}), 32'({4'd0, 3'b111, 1'b0}));

    // Start during CHECK discards the result
    g7.guessBtn = 1;
    step(1);
    chk("abort_check_isguess", 32'(g7.isGuess), 1);
    g7.guessBtn = 0; g7.start = 1;
    step(1);
    chk("abort_arm", 32'({g7.tries, g7.hint, g7.isGuess, g7.busy}), 32'({4'd0, 3'b111, 1'b0, 1'b1}));
    g7.start = 0;
    step(1);
    chk("abort_wait", 32'({g7.tries, g7.hint}), 32'({4'd0, 3'b111}));

    // Reset asserted while in CHECK
    g7.guessBtn = 1;
    step(1);
    chk("rst_check_isguess", 32'(g7.isGuess), 1);
    g7.guessBtn = 0;
    reset_n = 1'b0;
    #1;
    chk("rst_midgame", 32'(pk7()), 32'(RST_VAL));
    step(1);
    reset_n = 1'b1;
    g7.guessBtn = 1;
    step(2);
    chk("idle_after_rst", 32'(pk7()), 32'(RST_VAL));
    g7.guessBtn = 0;

    // Try limit of 3: three misses lose
    g3.start = 1;
    step(1);
    g3.start = 0;
    step(1);
    chk("l_wait", 32'(g3.number), 4'b1010);
    g3.sw_number = 4'b1011; g3.guessBtn = 1;
    step(1);
    chk("l1_isguess", 32'(g3.isGuess), 1);
    g3.guessBtn = 0;
    step(1);
    chk("l1", 32'({g3.hint, g3.tries, g3.lose, g3.busy}), 32'({3'b001, 4'd1, 1'b0, 1'b1}));
    g3.sw_number = 4'b1000; g3.guessBtn = 1;
    step(1);
    g3.guessBtn = 0;
    step(1);
    chk("l2", 32'({g3.hint, g3.tries, g3.lose, g3.busy}), 32'({3'b010, 4'd2, 1'b0, 1'b1}));
    g3.sw_number = 4'b0010; g3.guessBtn = 1;
    step(1);
    g3.guessBtn = 0;
    step(1);
    chk("l3_lose", 32'(pk3()), 32'({4'b1010, 4'b0010, 1'b0, 3'b100, 4'd3, 1'b0, 1'b1, 1'b0}));
    g3.sw_number = 4'b1010; g3.guessBtn = 1;
    step(1);
    chk("l4_isguess", 32'(g3.isGuess), 0);
    g3.guessBtn = 0;
    step(1);
    chk("l4_ignored", 32'({g3.tries, g3.lose, g3.win}), 32'({4'd3, 1'b1, 1'b0}));

    // Try limit of 3: win on the final try
    g3.start = 1;
    step(1);
    g3.start = 0;
    step(1);
    chk("w_restart", 32'({g3.tries, g3.lose, g3.hint}), 32'({4'd0, 1'b0, 3'b111}));
    g3.sw_number = 4'b0000; g3.guessBtn = 1;
    step(1);
    g3.guessBtn = 0;
    step(1);
    g3.sw_number = 4'b0001; g3.guessBtn = 1;
    step(1);
    g3.guessBtn = 0;
    step(1);
    chk("w2", 32'({g3.hint, g3.tries}), 32'({3'b100, 4'd2}));
    g3.sw_number = 4'b1010; g3.guessBtn = 1;
    step(1);
    g3.guessBtn = 0;
    step(1);
    chk("w3_final_win", 32'({g3.hint, g3.tries, g3.win, g3.lose, g3.busy}),
        32'({3'b000, 4'd3, 1'b1, 1'b0, 1'b0}));

    // Random secrets: fresh reset, first start five cycles later
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    g7.useRandom = 1;
    step(5);
    for (int g = 0; g < 15; g++) begin
      g7.start = 1;
      step(1);
      exp_num = tab[cnt % 15];
      g7.start = 0;
      step(1);
      chk($sformatf("rand_number_%0d", g), 32'(g7.number), 32'(exp_num));
      chk($sformatf("rand_nonzero_%0d", g), 32'(g7.number != 4'd0), 1);
      step(g % 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
